// File: rtl/prio_drain_encode.sv
// Priority drain encoder: captures a request vector and emits the index
// of each set bit in turn (lowest- or highest-first) over a ready/valid port.
module prio_drain_encode #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] in,
  input  logic         mode,
  output logic         in_ready,
  output logic [W-1:0] out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         last,
  output logic         zero,
  output logic [W:0]   count
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t       state, state_d;
  logic [N-1:0] pend, pend_d, pend_clr;
  logic         mode_q, mode_d;
  logic [W-1:0] out_q, out_d;
  logic         zero_q, zero_d;

  // hi=1: ascending scan, last hit wins -> highest set bit.
  // hi=0: descending scan, last hit wins -> lowest set bit.
  function automatic logic [W-1:0] pick(
    input logic [N-1:0] v,
    input logic         hi
  );
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (hi) begin
        if (v[i]) idx = W'(i);
      end else if (v[N-1-i]) begin
        idx = W'(N-1-i);
      end
    end
    return idx;
  endfunction

  function automatic logic [W:0] popcnt(
    input logic [N-1:0] v
  );
    logic [W:0] c;
    c = '0;
    for (int i = 0; i < N; i++)
      c = c + (W+1)'(v[i]);
    return c;
  endfunction

  always_comb begin
    state_d  = state;
    pend_d   = pend;
    mode_d   = mode_q;
    out_d    = out_q;
    zero_d   = 1'b0;
    pend_clr = pend & ~(N'(1) << out_q);
    case (state)
      IDLE: begin
        if (load) begin
          pend_d = in;
          mode_d = mode;
          if (|in) begin
            state_d = DRAIN;
            out_d   = pick(in, mode);
          end else begin
            zero_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          pend_d = pend_clr;
          if (|pend_clr) out_d = pick(pend_clr, mode_q);
          else state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pend   <= '0;
      mode_q <= 1'b0;
      out_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      state  <= state_d;
      pend   <= pend_d;
      mode_q <= mode_d;
      out_q  <= out_d;
      zero_q <= zero_d;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DRAIN);
  assign out       = out_q;
  assign zero      = zero_q;
  assign count     = out_valid ? popcnt(pend) : '0;
  assign last      = out_valid && (count == (W+1)'(1));

endmodule

// File: tb/tb_prio_drain_encode.sv
// Bench for prio_drain_encode: directed literal scenarios plus random
// traffic checked every cycle against a queue-based reference model.
module tb_prio_drain_encode;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [N-1:0] in_v = '0;
  logic         mode = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic [W-1:0] out;
  logic         out_valid;
  logic         last;
  logic         zero;
  logic [W:0]   count;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  // reference model: ordered queue of indices still to be emitted
  int mq[$];
  bit m_busy = 0;
  int m_out = 0;
  bit m_zero = 0;

  prio_drain_encode #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .load(load), .in(in_v), .mode(mode),
    .in_ready(in_ready), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .last(last), .zero(zero), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    m_zero = 0;
    if (rst) begin
      m_busy = 0;
      mq.delete();
      m_out = 0;
    end else if (!m_busy) begin
      if (load) begin
        mq.delete();
        for (int i = 0; i < N; i++) begin
          int b;
          b = mode ? N - 1 - i : i;
          if (in_v[b]) mq.push_back(b);
        end
        if (mq.size() == 0) m_zero = 1;
        else begin
          m_busy = 1;
          m_out = mq[0];
        end
      end
    end else if (out_ready) begin
      void'(mq.pop_front());
      if (mq.size() == 0) m_busy = 0;
      else m_out = mq[0];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m.in_ready", in_ready, !m_busy);
      chk("m.out_valid", out_valid, m_busy);
      chk("m.out", out, m_out);
      chk("m.count", count, m_busy ? mq.size() : 0);
      chk("m.last", last, m_busy && mq.size() == 1);
      chk("m.zero", zero, m_zero);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_out(input string nm, input int o, input int c,
                         input bit l);
    chk({nm, ".valid"}, out_valid, 1);
    chk({nm, ".out"}, out, o);
    chk({nm, ".count"}, count, c);
    chk({nm, ".last"}, last, l);
  endtask

  task automatic load_vec(input logic [N-1:0] v, input bit md);
    in_v = v;
    mode = md;
    load = 1;
    tick();
    load = 0;
  endtask

  initial begin
    tick();
    chk_en = 1;
    rst = 0;
    chk("rst.out", out, 0);
    chk("rst.valid", out_valid, 0);
    chk("rst.last", last, 0);
    chk("rst.zero", zero, 0);
    chk("rst.count", count, 0);
    chk("rst.in_ready", in_ready, 1);

    // lowest-first drain of 1010_0100
    out_ready = 1;
    load_vec(8'b1010_0100, 0);
    exp_out("a4lo0", 2, 3, 0); tick();
    exp_out("a4lo1", 5, 2, 0); tick();
    exp_out("a4lo2", 7, 1, 1); tick();
    chk("a4lo.in_ready", in_ready, 1);
    chk("a4lo.valid", out_valid, 0);
    chk("a4lo.hold", out, 7);

    // highest-first; a load on the final accept must be ignored
    load_vec(8'b1010_0100, 1);
    exp_out("a4hi0", 7, 3, 0); tick();
    exp_out("a4hi1", 5, 2, 0); tick();
    exp_out("a4hi2", 2, 1, 1);
    in_v = 8'hFF; load = 1;
    tick();
    load = 0;
    chk("final_ld.in_ready", in_ready, 1);
    chk("final_ld.valid", out_valid, 0);

    // all-zero vector
    load_vec(8'h00, 0);
    chk("zero.pulse", zero, 1);
    chk("zero.valid", out_valid, 0);
    chk("zero.in_ready", in_ready, 1);
    tick();
    chk("zero.end", zero, 0);

    // full vector with a 3-cycle stall at index 3
    load_vec(8'hFF, 0);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        out_ready = 0;
        for (int s = 0; s < 3; s++) begin
          exp_out("ff.stall", 3, 5, 0);
          tick();
        end
        out_ready = 1;
      end
      exp_out("ff", k, 8 - k, k == 7);
      tick();
    end
    chk("ff.done", out_valid, 0);

    // reset mid-drain
    load_vec(8'h0F, 0);
    exp_out("0f0", 0, 4, 0); tick();
    exp_out("0f1", 1, 3, 0);
    rst = 1; load = 1;
    tick();
    rst = 0; load = 0;
    chk("mrst.valid", out_valid, 0);
    chk("mrst.count", count, 0);
    chk("mrst.in_ready", in_ready, 1);
    load_vec(8'h80, 0);
    exp_out("80", 7, 1, 1); tick();

    // one-hot sweep, both orders
    for (int k = 0; k < N; k++) begin
      for (int md = 0; md < 2; md++) begin
        load_vec(8'(1 << k), md[0]);
        exp_out("onehot", k, 1, 1);
        tick();
        chk("onehot.idle", in_ready, 1);
      end
    end

    // random traffic, checked by the model only
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      load = ($urandom_range(0, 2) != 0);
      mode = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: in_v = '0;
        1: in_v = 8'(1 << $urandom_range(0, N - 1));
        default: in_v = 8'($urandom);
      endcase
      tick();
    end
    rst = 0; load = 0; out_ready = 1;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
